// File: rtl/alu_ctrl.sv
// alu_ctrl: issues one instruction at a time to an external combinational ALU and writes the result back into an 8x16 register file.
// Latency: accept edge -> writeback edge is 2 cycles; done pulses in the cycle after writeback (1 instr / 3 cycles peak).
// Backpressure: instr_ready is high only in IDLE; instr_valid outside IDLE is ignored. Optional flags via ALU_CTRL_FLAGS_EN.
module alu_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic              ld_en,
    input  logic [2:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              done,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
`ifdef ALU_CTRL_FLAGS_EN
    output logic              flag_z,
    output logic              flag_n,
`endif
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2:0]        rd_q, rd_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              done_q, done_d;
    logic [2:0]        wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
`ifdef ALU_CTRL_FLAGS_EN
    logic              flag_z_q, flag_z_d;
    logic              flag_n_q, flag_n_d;
`endif

    // instr[3:0] carries no meaning for this controller
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[3:0];

    // Next-state, operand latch and register-file write selection; ALU writeback is applied after ld_en so it wins on a collision
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        done_d    = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        regs_d    = regs_q;
`ifdef ALU_CTRL_FLAGS_EN
        flag_z_d  = flag_z_q;
        flag_n_d  = flag_n_q;
`endif
        if (ld_en) begin
            regs_d[ld_addr] = ld_data;
        end
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr[15:13];
                    rd_d    = instr[12:10];
                    // operands come from pre-edge register contents
                    a_d     = regs_q[instr[9:7]];
                    b_d     = regs_q[instr[6:4]];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                regs_d[rd_q] = alu_result;
                wb_addr_d    = rd_q;
                wb_data_d    = alu_result;
                done_d       = 1'b1;
`ifdef ALU_CTRL_FLAGS_EN
                flag_z_d     = (alu_result == '0);
                flag_n_d     = alu_result[DATA_W-1];
`endif
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and register file update with synchronous reset overriding everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            done_q    <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
`ifdef ALU_CTRL_FLAGS_EN
            flag_z_q  <= 1'b0;
            flag_n_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            done_q    <= done_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            regs_q    <= regs_d;
`ifdef ALU_CTRL_FLAGS_EN
            flag_z_q  <= flag_z_d;
            flag_n_q  <= flag_n_d;
`endif
        end
    end

    // Output drive; operands hold their last values while idle
    always_comb begin
        instr_ready = (state_q == S_IDLE);
        alu_op      = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        done        = done_q;
        wb_addr     = wb_addr_q;
        wb_data     = wb_data_q;
        rd_data     = regs_q[rd_addr];
`ifdef ALU_CTRL_FLAGS_EN
        flag_z      = flag_z_q;
        flag_n      = flag_n_q;
`endif
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural model of the external ALU.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        done;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic [2:0]  rd_addr;
    logic [15:0] rd_data;
`ifdef ALU_CTRL_FLAGS_EN
    logic        flag_z;
    logic        flag_n;
`endif

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    alu_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .done        (done),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
`ifdef ALU_CTRL_FLAGS_EN
        .flag_z      (flag_z),
        .flag_n      (flag_n),
`endif
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // External ALU model: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 signed compare
    always_comb begin
        case (alu_op)
            3'b000: alu_result = alu_a + alu_b;
            3'b001: alu_result = alu_a - alu_b;
            3'b010: alu_result = alu_a & alu_b;
            3'b011: alu_result = alu_a | alu_b;
            3'b100: alu_result = alu_a ^ alu_b;
            3'b101: alu_result = {alu_a[14:0], 1'b0};
            3'b110: alu_result = {1'b0, alu_a[15:1]};
            default: begin
                if ($signed(alu_a) < $signed(alu_b))      alu_result = 16'hFFFF;
                else if ($signed(alu_a) > $signed(alu_b)) alu_result = 16'h0001;
                else                                      alu_result = 16'h0000;
            end
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step();
        ld_en = 1'b0;
    endtask

    // Drives one instruction from IDLE and stops in the cycle where done should be high
    task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        instr = {op, rd, rs1, rs2, 4'b0};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hAAAA;
        step();
        step();
        ld_en = 1'b0;
        rst = 1'b0;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", instr_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", done); end
        total++; if ({alu_op, alu_a, alu_b} !== 35'd0) begin bad++; $display("FAIL reset_alu got %h/%h/%h want 0", alu_op, alu_a, alu_b); end
        total++; if ({wb_addr, wb_data} !== 19'd0) begin bad++; $display("FAIL reset_wb got %h/%h want 0", wb_addr, wb_data); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_reg%0d got %h want 0000", i, rd_data); end
        end
`ifdef ALU_CTRL_FLAGS_EN
        total++; if ({flag_z, flag_n} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b%b want 00", flag_z, flag_n); end
`endif
    endtask

    task automatic test_add();
        load(3'd1, 16'h0005);
        load(3'd2, 16'h0003);
        instr = {3'b000, 3'd3, 3'd1, 3'd2, 4'b0};
        instr_valid = 1'b1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready_idle got %b want 1", instr_ready); end
        step();
        instr_valid = 1'b0;
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL add_ready_issue got %b want 0", instr_ready); end
        total++; if ({alu_op, alu_a, alu_b} !== {3'b000, 16'h0005, 16'h0003}) begin bad++; $display("FAIL add_operands got %h/%h/%h want 0/0005/0003", alu_op, alu_a, alu_b); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_issue got %b want 0", done); end
        step();
        total++; if (done !== 1'b0 || instr_ready !== 1'b0) begin bad++; $display("FAIL add_capture got done=%b rdy=%b want 0/0", done, instr_ready); end
        step();
        rd_addr = 3'd3; #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL add_done got %b want 1", done); end
        total++; if (wb_addr !== 3'd3 || wb_data !== 16'h0008) begin bad++; $display("FAIL add_wb got %h/%h want 3/0008", wb_addr, wb_data); end
        total++; if (rd_data !== 16'h0008) begin bad++; $display("FAIL add_r3 got %h want 0008", rd_data); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL add_ready_done got %b want 1", instr_ready); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got %b want 0", done); end
    endtask

    task automatic test_compare_sub();
        load(3'd1, 16'h0003);
        load(3'd2, 16'h0005);
        issue(3'b111, 3'd4, 3'd1, 3'd2);
        rd_addr = 3'd4; #1;
        total++; if (done !== 1'b1 || wb_data !== 16'hFFFF) begin bad++; $display("FAIL cmp_wb got done=%b %h want 1 FFFF", done, wb_data); end
        total++; if (rd_data !== 16'hFFFF) begin bad++; $display("FAIL cmp_r4 got %h want FFFF", rd_data); end
`ifdef ALU_CTRL_FLAGS_EN
        total++; if ({flag_z, flag_n} !== 2'b01) begin bad++; $display("FAIL cmp_flags got %b%b want 01", flag_z, flag_n); end
`endif
        issue(3'b001, 3'd1, 3'd1, 3'd1);
        rd_addr = 3'd1; #1;
        total++; if (wb_addr !== 3'd1 || wb_data !== 16'h0000) begin bad++; $display("FAIL sub_wb got %h/%h want 1/0000", wb_addr, wb_data); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL sub_r1 got %h want 0000", rd_data); end
`ifdef ALU_CTRL_FLAGS_EN
        total++; if ({flag_z, flag_n} !== 2'b10) begin bad++; $display("FAIL sub_flags got %b%b want 10", flag_z, flag_n); end
`endif
    endtask

    task automatic test_alias();
        load(3'd2, 16'h8001);
        issue(3'b101, 3'd2, 3'd2, 3'd0);
        rd_addr = 3'd2; #1;
        total++; if (wb_data !== 16'h0002 || rd_data !== 16'h0002) begin bad++; $display("FAIL alias_r2 got wb=%h rd=%h want 0002", wb_data, rd_data); end
        step();
        total++; if (alu_a !== 16'h8001 || alu_op !== 3'b101) begin bad++; $display("FAIL alias_hold got %h/%h want 8001/5", alu_a, alu_op); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        logic [15:0] exp_wb = 16'h0009;
        load(3'd1, 16'h0001);
        instr = {3'b000, 3'd3, 3'd3, 3'd1, 4'b0};
        instr_valid = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 8) instr_valid = 1'b0;
            total++; if (instr_ready !== (k % 3 == 2) || done !== (k % 3 == 2)) begin bad++; $display("FAIL b2b_cycle%0d got rdy=%b done=%b want %b", k, instr_ready, done, (k % 3 == 2)); end
            if (done === 1'b1) begin
                ndone++;
                total++; if (wb_data !== exp_wb) begin bad++; $display("FAIL b2b_wb%0d got %h want %h", ndone, wb_data, exp_wb); end
                exp_wb = exp_wb + 16'd1;
            end
        end
        total++; if (ndone != 3) begin bad++; $display("FAIL b2b_count got %0d want 3", ndone); end
        step();
        total++; if (done !== 1'b0 || instr_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got done=%b rdy=%b want 0/1", done, instr_ready); end
    endtask

    task automatic test_collision();
        load(3'd1, 16'h0F0F);
        load(3'd2, 16'h00FF);
        instr = {3'b010, 3'd5, 3'd1, 3'd2, 4'b0};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 3'd1; ld_data = 16'hFFFF;
        step();
        total++; if (alu_a !== 16'h0F0F) begin bad++; $display("FAIL coll_operand got %h want 0F0F", alu_a); end
        ld_en = 1'b1; ld_addr = 3'd5; ld_data = 16'h1234;
        step();
        ld_en = 1'b0;
        rd_addr = 3'd5; #1;
        total++; if (rd_data !== 16'h000F || wb_data !== 16'h000F) begin bad++; $display("FAIL coll_r5 got rd=%h wb=%h want 000F", rd_data, wb_data); end
        rd_addr = 3'd1; #1;
        total++; if (rd_data !== 16'hFFFF) begin bad++; $display("FAIL coll_r1 got %h want FFFF", rd_data); end
    endtask

    task automatic test_reset_mid();
        load(3'd6, 16'h6666);
        instr = {3'b000, 3'd7, 3'd6, 3'd6, 4'b0};
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (instr_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rmid_state got rdy=%b done=%b want 1/0", instr_ready, done); end
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_nodone got %b want 0", done); end
        step();
        total++; if (done !== 1'b0 || wb_data !== 16'h0000 || alu_a !== 16'h0000) begin bad++; $display("FAIL rmid_outs got done=%b wb=%h a=%h want 0", done, wb_data, alu_a); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i); #1;
            total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL rmid_reg%0d got %h want 0000", i, rd_data); end
        end
`ifdef ALU_CTRL_FLAGS_EN
        total++; if ({flag_z, flag_n} !== 2'b00) begin bad++; $display("FAIL rmid_flags got %b%b want 00", flag_z, flag_n); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 16'h0000;
        ld_en = 1'b0;
        ld_addr = 3'd0;
        ld_data = 16'h0000;
        rd_addr = 3'd0;
        test_reset();
        test_add();
        test_compare_sub();
        test_alias();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Instruction-issuing controller that drives the 16-bit, 3-bit-opcode combinational ALU and captures its result. It accepts one instruction word at a time over a valid/ready handshake. It reads two operands from an internal 8x16 register file, presents op/a/b to the ALU, then writes the ALU result back. It is the initiator side of the ALU interface; the ALU instance is external and connects through the alu_* ports.

Parameters:
DATA_W, 16, operand/result/register width
NREG, 8, register count; fixed by the 3-bit register fields

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
instr_valid  input  1  instruction word present
instr_ready  output  1  controller can accept an instruction (high only in IDLE)
instr  input  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored
ld_en  input  1  direct register load strobe
ld_addr  input  3  load target register
ld_data  input  16  load data
alu_op  output  3  opcode to ALU
alu_a  output  16  operand A to ALU
alu_b  output  16  operand B to ALU
alu_result  input  16  combinational result from ALU
done  output  1  one-cycle pulse at writeback
wb_addr  output  3  register written at done
wb_data  output  16  value written at done
rd_addr  input  3  debug read address
rd_data  output  16  combinational read of register rd_addr

Behaviour:
- Reset (rst=1 at clock edge):
  - All 8 registers clear to 0.
  - State goes to IDLE.
  - alu_op=0, alu_a=0, alu_b=0, done=0, wb_addr=0, wb_data=0.
  - rst overrides every other input, including an accept or ld_en in the same cycle. Reset mid-instruction drops that instruction with no writeback.
- State machine: IDLE -> ISSUE -> CAPTURE -> IDLE.
  - IDLE: instr_ready=1. When instr_valid && instr_ready at an edge:
    - latch op, rd;
    - latch alu_a=reg[rs1] and alu_b=reg[rs2], using register values before that edge's writes;
    - go to ISSUE.
  - ISSUE: instr_ready=0. alu_op/alu_a/alu_b are stable; the ALU settles combinationally. Go to CAPTURE.
  - CAPTURE: sample alu_result into reg[rd], wb_data and wb_addr=rd. Pulse done=1 for the following cycle. Go to IDLE.
- Latency and throughput:
  - Accept edge to writeback edge is 2 cycles; done is high in the cycle after the writeback edge.
  - The next instruction can be accepted in the cycle done is high. Peak throughput is 1 instruction per 3 cycles.
- alu_op/alu_a/alu_b hold their last values in IDLE; they are not cleared after use.
- Operand aliasing: rs1==rs2, rd==rs1 and rd==rs2 are all legal. Operands are the pre-instruction values.
- Register write collision: if ld_en targets rd on the CAPTURE edge, the ALU writeback wins. An ld_en to any other address in the same cycle still takes effect.
- ld_en is honoured in every state. Loading a source register after accept does not change the latched operands.
- rd_data is combinational and shows the register value after the last edge. There is no write-through.
- All opcodes are passed unmodified. Compare (111) results 0x0000, 0x0001 or 0xFFFF are written back as-is. The controller performs no arithmetic.
- instr_valid while not in IDLE is ignored. The source must hold the word until instr_ready.

Optional Feature:
- Macro: ALU_CTRL_FLAGS_EN.
- Defined: adds outputs flag_z (1) and flag_n (1). They are registered at the CAPTURE edge:
  - flag_z = (alu_result==0);
  - flag_n = alu_result[15].
- Flags reset to 0 and hold between instructions. A reset mid-instruction leaves them 0.
- Not defined: the ports do not exist and there is no flag logic.

Test Plan:
- Load r1=0x0005, r2=0x0003. Issue op=000, rd=3, rs1=1, rs2=2 -> done one cycle after the writeback edge, wb_addr=3, wb_data=0x0008, rd_data(3)=0x0008.
- Load r1=0x0003, r2=0x0005. Issue op=111, rd=4, rs1=1, rs2=2 -> r4=0xFFFF.
  - Then op=001, rd=1, rs1=1, rs2=1 -> r1=0x0000. With FLAGS_EN: z=1, n=0.
- Issue op=101, rd=2, rs1=2, rs2=0 with r2=0x8001 -> r2=0x0002.
  - Aliased source/destination reads the old value.
- Hold instr_valid high continuously with 3 back-to-back adds -> instr_ready low in ISSUE/CAPTURE, one acceptance per 3 cycles, 3 done pulses.
- Issue op=010 with rd=5 and drive ld_en to r5=0x1234 on the CAPTURE edge -> r5 holds the ALU result, not 0x1234.
- Assert rst in ISSUE -> no done pulse, all registers read 0, instr_ready=1 the next cycle.
